pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined N-bit adder/subtractor. It is the next-generation replacement for the fixed-width ripple-carry adder used in the datapath examples.
- The carry chain is split into STAGES equal segments, with a register boundary between segments. Carry ripples through one segment per clock.
- Operands enter and results leave through valid/ready handshakes, so the block sits between streaming producers and consumers in the demo datapaths.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of carry segments = pipeline depth; legal range 1..WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out; in subtract mode 1 = no borrow
- (only with flags feature) ovf  output  1  signed overflow
- (only with flags feature) zero  output  1  sum == 0

Behaviour:
- Segment width: SEG = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] plus the carry registered from stage k-1.
- Stage 0 carry-in:
  - add: cin
  - sub: 1, with b inverted; the cin port is ignored.
- Upper, not-yet-added operand segments and already-computed lower sum segments travel with the beat through skew registers. Each beat is fully self-contained; no data is shared between beats.
- Each stage holds a valid bit. The pipeline advances as a whole on adv = !out_valid || out_ready:
  - On adv, every stage loads from its predecessor.
  - Stage 0 loads the input beat when in_valid, otherwise a bubble (valid = 0).
- in_ready = adv (purely combinational from out_valid/out_ready; no dependency on in_valid).
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid, when not stalled.
- Throughput: one result per cycle with out_ready held high.
- Bubbles are not collapsed; they propagate as invalid stages.
- Stall: when out_valid && !out_ready, all stage registers hold and sum/cout stay stable. No beat is lost or duplicated.
- Output behaviour:
  - sum, cout, flags are registered outputs of the last stage.
  - Their value while out_valid = 0 is don't-care for the bench, but the RTL holds the last value.
- Arithmetic:
  - Result is {cout, sum} = a + b + cin (add) or a + ~b + 1 (sub), modulo 2^(WIDTH+1).
  - Wrap-around is silent; cout reports the wrap.
- Reset:
  - Asserting rst_n low at any time, including mid-stream, clears all valid bits immediately.
  - out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0.
  - In-flight beats are discarded.
  - in_ready = 1 while in reset and on the first cycle after release.
- STAGES = 1 degenerates to a single registered adder with latency 1.

Optional Feature:
- Macro PIPELINED_ADDER_FLAGS_EN.
- When defined:
  - ovf and zero ports exist.
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
  - zero = (sum == 0).
  - Both are registered and aligned with sum, reset to 0.
- When undefined: the ports are absent and no flag logic is generated.

Test Plan:
- Reset release, WIDTH=32, STAGES=4: a=0x0000_0005, b=0x0000_0003, cin=1, sub=0 -> out_valid rises exactly 4 cycles after transfer; sum=0x0000_0009, cout=0.
- Carry across all segments: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x0000_0000, cout=1, zero=1, ovf=0 (flags build).
- Subtract: a=0x0000_0003, b=0x0000_0005, sub=1, cin=1 (ignored) -> sum=0xFFFF_FFFE, cout=0. Signed overflow case: a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1.
- Streaming: 8 back-to-back beats (a=i, b=i, i=0..7) with out_ready=1 -> 8 consecutive results 0,2,...,14 in order, no gaps.
- Backpressure: same 8 beats, out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, sum stable, results still 0..14 in order with none lost or duplicated.
- Mid-operation reset: pull rst_n low with 3 beats in flight -> out_valid=0 and sum=0 immediately; after release the next beat (a=1, b=1) yields sum=2 after 4 cycles and no stale results appear.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry ripples through one SEG-bit segment per clock.
// Define PIPELINED_ADDER_FLAGS_EN to add registered signed-overflow (ovf) and zero flags.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Operands are shifted down a segment per stage, so every stage adds the low SEG bits;
  // finished sum segments are shifted in from the top and land in place after the last stage.
  logic [WIDTH-1:0]  aQ     [STAGES];
  logic [WIDTH-1:0]  bQ     [STAGES];
  logic [WIDTH-1:0]  sumQ   [STAGES];
  logic [STAGES-1:0] carryQ;
  logic [STAGES-1:0] validQ;

  logic [WIDTH-1:0]  srcA   [STAGES];
  logic [WIDTH-1:0]  srcB   [STAGES];
  logic [WIDTH-1:0]  srcSum [STAGES];
  logic [STAGES-1:0] srcC;
  logic [STAGES-1:0] srcV;

  logic [WIDTH-1:0]  aD     [STAGES];
  logic [WIDTH-1:0]  bD     [STAGES];
  logic [WIDTH-1:0]  sumD   [STAGES];
  logic [STAGES-1:0] carryD;
  logic [SEG:0]      segRes [STAGES];

  logic adv;

  assign adv = !validQ[LAST] || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    if (k == 0) begin : gFirst
      // Subtraction is a + ~b + 1; the cin port only matters in add mode.
      assign srcA[k]   = a;
      assign srcB[k]   = sub ? ~b : b;
      assign srcC[k]   = sub | cin;
      assign srcSum[k] = '0;
      assign srcV[k]   = in_valid;
    end else begin : gNext
      assign srcA[k]   = aQ[k-1];
      assign srcB[k]   = bQ[k-1];
      assign srcC[k]   = carryQ[k-1];
      assign srcSum[k] = sumQ[k-1];
      assign srcV[k]   = validQ[k-1];
    end

    assign segRes[k] = {1'b0, srcA[k][SEG-1:0]} + {1'b0, srcB[k][SEG-1:0]}
                     + (SEG+1)'(srcC[k]);
    assign aD[k]     = srcA[k] >> SEG;
    assign bD[k]     = srcB[k] >> SEG;
    assign sumD[k]   = (srcSum[k] >> SEG) | (WIDTH'(segRes[k][SEG-1:0]) << (WIDTH - SEG));
    assign carryD[k] = segRes[k][SEG];
  end

  // Valid bits advance on every adv; data registers only load real beats so outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      carryQ <= '0;
      for (int k = 0; k < STAGES; k++) begin
        aQ[k]   <= '0;
        bQ[k]   <= '0;
        sumQ[k] <= '0;
      end
    end else if (adv) begin
      validQ <= srcV;
      for (int k = 0; k < STAGES; k++) begin
        if (srcV[k]) begin
          aQ[k]     <= aD[k];
          bQ[k]     <= bD[k];
          sumQ[k]   <= sumD[k];
          carryQ[k] <= carryD[k];
        end
      end
    end
  end

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic ovfQ;
  logic zeroQ;
  logic msbCarryIn;

  // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
  assign msbCarryIn = srcA[LAST][SEG-1] ^ srcB[LAST][SEG-1] ^ segRes[LAST][SEG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfQ  <= 1'b0;
      zeroQ <= 1'b0;
    end else if (adv && srcV[LAST]) begin
      ovfQ  <= msbCarryIn ^ carryD[LAST];
      zeroQ <= (sumD[LAST] == '0);
    end
  end

  assign ovf  = ovfQ;
  assign zero = zeroQ;
`endif

  assign in_ready  = adv;
  assign out_valid = validQ[LAST];
  assign sum       = sumQ[LAST];
  assign cout      = carryQ[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4): expected results are queued
// when a beat is accepted and compared when the matching result leaves the pipeline.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    int               tIn;
    bit               chkLat;
  } expT;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic             ovf;
  logic             zero;
`endif

  expT              expQ[$];
  int               checks    = 0;
  int               failures  = 0;
  int               cycleCnt  = 0;
  int               stallSeen = 0;
  bit               stallPrev = 0;
  logic [WIDTH-1:0] heldSum   = '0;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one beat, waits (bounded) for acceptance, and queues the reference result.
  task automatic applyStimulus(input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                               input logic cinV, input logic subV, input bit lat);
    expT              e;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    logic             c;
    int               w;
    a        = aV;
    b        = bV;
    cin      = cinV;
    sub      = subV;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    bb       = subV ? ~bV : bV;
    c        = subV ? 1'b1 : cinV;
    full     = {1'b0, aV} + {1'b0, bb} + (WIDTH+1)'(c);
    e.sum    = full[WIDTH-1:0];
    e.cout   = full[WIDTH];
    e.ovf    = (aV[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != aV[WIDTH-1]);
    e.zero   = (full[WIDTH-1:0] == '0);
    e.tIn    = cycleCnt + 1;
    e.chkLat = lat;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (expQ.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output side: stall stability plus scoreboard comparison on every output transfer.
  always @(negedge clk) begin
    expT e;
    if (rst_n) begin
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", in_ready, 0);
        if (stallPrev) checkOutput("stall_sum_stable", sum, heldSum);
        heldSum   = sum;
        stallPrev = 1'b1;
        stallSeen++;
      end else begin
        stallPrev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sum", sum, e.sum);
          checkOutput("cout", cout, e.cout);
`ifdef PIPELINED_ADDER_FLAGS_EN
          checkOutput("ovf", ovf, e.ovf);
          checkOutput("zero", zero, e.zero);
`endif
          if (e.chkLat) checkOutput("latency", cycleCnt - e.tIn + 1, STAGES);
        end
      end
    end
  end

  initial begin
    #200000;
    checkOutput("watchdog", 1, 0);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    checkOutput("reset_in_ready", in_ready, 1);
`ifdef PIPELINED_ADDER_FLAGS_EN
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_zero", zero, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 1'b1);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    waitDrain();

    for (int i = 0; i < 8; i++) applyStimulus(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, 1'b1);
    waitDrain();

    // Same stream with a three-cycle consumer stall once results are flowing.
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("stall_cycles", stallSeen, 3);

    for (int i = 0; i < 3; i++) applyStimulus(32'h10, 32'h20, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_sum", sum, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    waitDrain();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
